jts16_cabin_mux: RTL

- Parametrised cabinet-input multiplexer for the S16 main CPU I/O window (c4xxxx).
- Replaces per-game inline port logic and serves three game modes:
  - standard two-player digital;
  - scanned N-player digital (Passing Shot style);
  - analog two-channel (SDI style).
- Adds coin-pulse stretching and an explicit read-strobe counter.
- Sits between the address decoder (io_cs, sel, addr) and the main CPU data-in mux; returns an 8-bit registered value.

---
 rtl/jts16_cabin_mux_if.sv | 25 ++
 rtl/jts16_cabin_mux.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jts16_cabin_mux_if.sv
// CPU-side view of the c4xxxx cabinet I/O window: select, bank, port index and returned byte.
// Latency: none inside the interface; the slave registers dout one clk after the inputs.
// Backpressure: none; the master holds io_cs high for as long as the access lasts.
interface jts16_cabin_mux_if;
   logic       io_cs;   // I/O window select, high for the whole CPU access
   logic [1:0] sel;     // A[13:12]: 0 PPI, 1 cabinet ports, 2 DIP switches, 3 unused
   logic [1:0] addr;    // A[2:1] port index
   logic [7:0] dout;    // registered port data back to the CPU data-in mux

   // CPU / address decoder side
   modport master (
      output io_cs,
      output sel,
      output addr,
      input  dout
   );

   // Cabinet multiplexer side
   modport slave (
      input  io_cs,
      input  sel,
      input  addr,
      output dout
   );
endinterface

// File: rtl/jts16_cabin_mux.sv
// Cabinet-input multiplexer for the S16 main CPU I/O window: standard, scanned and analog modes.
// Latency: dout follows the inputs one clk later while io_cs is high; reads FF one clk after io_cs drops.
// Backpressure: none; the CPU holds io_cs for the access and samples dout whenever it likes.
module jts16_cabin_mux #(
   parameter int PLAYERS   = 4,   // digital joystick/start channels, 2..4
   parameter int ANA       = 2,   // 16-bit analog channels, 1..2
   parameter int COIN_HOLD = 16,  // minimum cycles a coin event is shown low (>= 1)
   parameter int CW        = 2    // scan counter width, 2**CW >= PLAYERS
)(
   input  logic                 rst,
   input  logic                 clk,
   jts16_cabin_mux_if.slave     io_bus,
   input  logic [1:0]           i_mode,
   input  logic                 i_ana_neg,
   input  logic [8*PLAYERS-1:0] i_joystick,
   input  logic [16*ANA-1:0]    i_joyana,
   input  logic [PLAYERS-1:0]   i_start_button,
   input  logic [1:0]           i_coin_input,
   input  logic                 i_service,
   input  logic                 i_dip_test,
   input  logic [7:0]           i_dipsw_a,
   input  logic [7:0]           i_dipsw_b,
   output logic [CW-1:0]        o_scan_cnt
);

   localparam int              CCW       = $clog2(COIN_HOLD + 1);
   localparam logic [CCW-1:0]  COIN_LOAD = CCW'(COIN_HOLD);
   localparam logic [CW-1:0]   SCAN_LAST = CW'(PLAYERS - 1);

   localparam logic [1:0] MODE_SCAN = 2'd1;
   localparam logic [1:0] MODE_ANA  = 2'd2;

   localparam logic [1:0] SEL_CAB   = 2'd1;
   localparam logic [1:0] SEL_DIP   = 2'd2;

   // Sega "sorted" joystick layout used by the standard boards
   function automatic logic [7:0] f_sort(input logic [7:0] j);
      return {j[1:0], j[3:2], j[7], j[5:4], j[6]};
   endfunction

   // Passing Shot per-player layout returned by the scanned port
   function automatic logic [7:0] f_pass(input logic [7:0] j);
      return {j[7:4], j[1:0], j[3:2]};
   endfunction

   // Analog byte: low byte as-is, or two's complement of the high byte when negated
   function automatic logic [7:0] f_ana(input logic [15:0] a, input logic neg);
      return neg ? 8'(~a[15:8] + 8'd1) : a[7:0];
   endfunction

   // ------------------------------------------------------------------
   // Per-player views, padded to four players with idle (all ones) bits
   // so the system port can always take start[3:2] without range checks.
   // ------------------------------------------------------------------
   logic [7:0] w_joy [4];
   logic [3:0] w_start;

   for (genvar g = 0; g < 4; g++) begin : g_player
      if (g < PLAYERS) begin : g_real
         assign w_joy[g]   = i_joystick[8*g +: 8];
         assign w_start[g] = i_start_button[g];
      end else begin : g_idle
         assign w_joy[g]   = 8'hFF;
         assign w_start[g] = 1'b1;
      end
   end

   logic [7:0] w_sort_p1;
   logic [7:0] w_sort_p2;
   logic [7:0] w_ana_first;
   logic [7:0] w_ana_last;

   assign w_sort_p1   = f_sort(w_joy[0]);
   assign w_sort_p2   = f_sort(w_joy[1]);
   assign w_ana_first = f_ana(i_joyana[15:0], i_ana_neg);
   assign w_ana_last  = f_ana(i_joyana[16*(ANA-1) +: 16], i_ana_neg);

   logic w_mode_scan;
   logic w_mode_ana;

   // Mode 3 falls through to standard behaviour because neither flag is set
   assign w_mode_scan = (i_mode == MODE_SCAN);
   assign w_mode_ana  = (i_mode == MODE_ANA);

   // ------------------------------------------------------------------
   // Access strobe. r_armed keeps an access that is already in progress
   // when reset releases from being counted as a new one: the first strobe
   // needs io_cs to have been seen low for a clock after reset.
   // ------------------------------------------------------------------
   logic r_last_cs;
   logic r_armed;
   logic w_strobe;

   assign w_strobe = io_bus.io_cs & ~r_last_cs & r_armed;

   // Track the previous select level and arm once the bus has been idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_cs <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_last_cs <= io_bus.io_cs;
         r_armed   <= r_armed | ~io_bus.io_cs;
      end
   end

   // ------------------------------------------------------------------
   // Scan counter: only moves on a mode-1 cabinet strobe. An addr-0 read
   // rewinds it, each addr-1 read advances it with wrap at PLAYERS-1.
   // ------------------------------------------------------------------
   logic [CW-1:0] r_scan_cnt;
   logic [CW-1:0] w_scan_nxt;
   logic [CW-1:0] w_scan_idx;
   logic [7:0]    w_scan_joy;

   // Next scan count from the strobe and the port being addressed
   always_comb begin
      w_scan_nxt = r_scan_cnt;
      if (w_strobe && w_mode_scan && io_bus.sel == SEL_CAB) begin
         if (io_bus.addr == 2'd0) begin
            w_scan_nxt = '0;
         end else if (io_bus.addr == 2'd1) begin
            w_scan_nxt = (r_scan_cnt == SCAN_LAST) ? '0 : r_scan_cnt + 1'b1;
         end
      end
   end

   // The player shown is the one just stepped past, so a rewound counter
   // still points at the last player until the first addr-1 strobe.
   assign w_scan_idx = (w_scan_nxt == '0) ? SCAN_LAST : w_scan_nxt - 1'b1;

   // Pick the scanned player's joystick byte
   always_comb begin
      w_scan_joy = 8'hFF;
      for (int p = 0; p < PLAYERS; p++) begin
         if (w_scan_idx == CW'(p)) begin
            w_scan_joy = w_joy[p];
         end
      end
   end

   // Hold the scan counter between strobes, in every mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_cnt <= '0;
      end else begin
         r_scan_cnt <= w_scan_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Coin stretch: a coin-low sample reloads COIN_HOLD, then the counter
   // drains to zero. The coin reads low while the input is low or the
   // counter is still draining, so a 1-cycle pulse shows for HOLD+1 clocks.
   // ------------------------------------------------------------------
   logic [CCW-1:0] r_coin_cnt [2];
   logic [1:0]     w_coin_s;

   // Reload on coin low, otherwise count down and stick at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            r_coin_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (!i_coin_input[c]) begin
               r_coin_cnt[c] <= COIN_LOAD;
            end else if (r_coin_cnt[c] != '0) begin
               r_coin_cnt[c] <= r_coin_cnt[c] - 1'b1;
            end
         end
      end
   end

   // Stretched active-low coin levels presented on the system port
   always_comb begin
      w_coin_s = 2'b11;
      for (int c = 0; c < 2; c++) begin
         w_coin_s[c] = i_coin_input[c] & (r_coin_cnt[c] == '0);
      end
   end

   // ------------------------------------------------------------------
   // Port data
   // ------------------------------------------------------------------
   logic [7:0] w_sys;
   logic [7:0] w_dout_nxt;

   // System port: starts, service, test and coins, top bits vary by mode
   always_comb begin
      w_sys = {2'b11, w_start[1:0], i_service, i_dip_test, w_coin_s};
      if (w_mode_ana) begin
         w_sys[7:6] = {w_joy[1][4], w_joy[0][4]};
      end else if (w_mode_scan) begin
         w_sys[7:6] = w_start[3:2];
      end
   end

   // Select the byte for the addressed port; unhandled banks read FF
   always_comb begin
      w_dout_nxt = 8'hFF;
      case (io_bus.sel)
         SEL_CAB: begin
            case (io_bus.addr)
               2'd0: w_dout_nxt = w_sys;
               2'd1: begin
                  if (w_mode_scan) begin
                     w_dout_nxt = f_pass(w_scan_joy);
                  end else if (w_mode_ana) begin
                     w_dout_nxt = w_ana_first;
                  end else begin
                     w_dout_nxt = w_sort_p1;
                  end
               end
               2'd2: begin
                  if (w_mode_ana) begin
                     w_dout_nxt = {w_sort_p2[7:4], w_sort_p1[7:4]};
                  end
               end
               default: begin
                  w_dout_nxt = w_mode_ana ? w_ana_last : w_sort_p2;
               end
            endcase
         end
         SEL_DIP: w_dout_nxt = io_bus.addr[0] ? i_dipsw_b : i_dipsw_a;
         default: w_dout_nxt = 8'hFF;
      endcase
   end

   logic [7:0] r_dout;

   // Register the selected byte during an access, park at FF otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= 8'hFF;
      end else if (io_bus.io_cs) begin
         r_dout <= w_dout_nxt;
      end else begin
         r_dout <= 8'hFF;
      end
   end

   assign io_bus.dout = r_dout;
   assign o_scan_cnt  = r_scan_cnt;

endmodule
